// File: rtl/pdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pdm_pkg
// Description : Shared types and helpers for the multi-channel PDM/PWM
//               modulator (mode encoding, select-width helper).
// Revision    : 1.0 - initial release
// ============================================================================
package pdm_pkg;

    // Per-frame modulation scheme, latched at every frame start
    typedef enum logic {
        PDM_MODE_SD  = 1'b0,
        PDM_MODE_PWM = 1'b1
    } pdm_mode_e;

    // Width of an index/counter able to address n items, never below one bit
    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_channel.sv
`default_nettype none
// ============================================================================
// Module      : pdm_channel
// Description : One modulator lane. Holds the double-buffered setpoint
//               (shadow/active), the sigma-delta accumulator and the
//               registered output bit. Frame/slot timing comes from the top.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_channel
    import pdm_pkg::*;
#(
    parameter int MOD_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [MOD_WIDTH-1:0] wr_data,
    input  logic                 commit,
    input  logic                 slot_tick,
    input  logic [MOD_WIDTH-1:0] slot_new,
    input  logic                 mode_act,
    input  logic                 acc_clear,
    input  logic                 out_clear,
    output logic                 pdm_out
);

    logic [MOD_WIDTH-1:0] shadow_q, shadow_d;
    logic [MOD_WIDTH-1:0] active_q, active_d;
    logic [MOD_WIDTH-1:0] acc_q,    acc_d;
    logic                 out_q,    out_d;

    logic [MOD_WIDTH-1:0] w_sp_eff;
    logic [MOD_WIDTH-1:0] w_acc_eff;
    logic [MOD_WIDTH:0]   w_sum;
    pdm_mode_e            w_mode;

    // Next-state: shadow capture, commit, and per-slot output computation
    always_comb begin
        w_mode    = pdm_mode_e'(mode_act);
        // On a commit cycle the slot-0 bit is computed from the value being
        // committed; a write in that same cycle only reaches the shadow.
        w_sp_eff  = commit ? shadow_q : active_q;
        w_acc_eff = acc_clear ? '0 : acc_q;
        w_sum     = {1'b0, w_acc_eff} + {1'b0, w_sp_eff};

        shadow_d  = wr_en  ? wr_data  : shadow_q;
        active_d  = commit ? shadow_q : active_q;
        acc_d     = acc_clear ? '0 : acc_q;
        out_d     = out_q;

        if (out_clear) begin
            out_d = 1'b0;
        end else if (slot_tick) begin
            if (w_mode == PDM_MODE_SD) begin
                out_d = w_sum[MOD_WIDTH];
                acc_d = w_sum[MOD_WIDTH-1:0];
            end else begin
                out_d = (slot_new < w_sp_eff);
            end
        end
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
            acc_q    <= '0;
            out_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
        end
    end

    assign pdm_out = out_q;

endmodule
`default_nettype wire

// File: rtl/pdm_modulator_mc.sv
`default_nettype none
// ============================================================================
// Module      : pdm_modulator_mc
// Description : Multi-channel sigma-delta / PWM modulator. Owns the slot
//               divider, slot counter, busy flag and frame control; each
//               output lane is a pdm_channel instance.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_modulator_mc
    import pdm_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int MOD_WIDTH      = 8,
    parameter int PDM_PERIOD_DIV = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 ena,
    input  logic                                 mode,
    input  logic                                 wr_en,
    input  logic [pdm_pkg::sel_width(CHANNELS)-1:0] wr_ch,
    input  logic [MOD_WIDTH-1:0]                 wr_data,
    output logic [CHANNELS-1:0]                  pdm_out,
    output logic                                 frame_strobe,
    output logic                                 busy
);

    localparam int CHW  = sel_width(CHANNELS);
    localparam int DIVW = sel_width(PDM_PERIOD_DIV);
    localparam logic [DIVW-1:0]      C_DIV_LAST  = DIVW'(PDM_PERIOD_DIV - 1);
    localparam logic [MOD_WIDTH-1:0] C_SLOT_LAST = '1;

    logic [DIVW-1:0]      div_cnt_q, div_cnt_d;
    logic [MOD_WIDTH-1:0] slot_q,    slot_d;
    pdm_mode_e            mode_act_q, mode_act_d;
    logic                 busy_q,    busy_d;
    logic                 strobe_q,  strobe_d;

    logic                 w_slot_end;
    logic                 w_frame_last;
    logic                 w_frame_start;
    logic                 w_frame_stop;
    logic                 w_slot_tick;
    logic [MOD_WIDTH-1:0] w_slot_new;
    pdm_mode_e            w_mode_in;
    pdm_mode_e            w_mode_eff;
    logic                 w_acc_clear;

    // Frame/slot boundary decode shared by all channels
    always_comb begin
        w_mode_in     = pdm_mode_e'(mode);
        w_slot_end    = busy_q && (div_cnt_q == C_DIV_LAST);
        w_frame_last  = w_slot_end && (slot_q == C_SLOT_LAST);
        // Start from idle, or chain straight into the next frame without a gap
        w_frame_start = ena && (!busy_q || w_frame_last);
        w_frame_stop  = w_frame_last && !ena;
        w_slot_tick   = w_frame_start || (w_slot_end && !w_frame_last);
        w_slot_new    = w_frame_start ? '0 : (slot_q + 1'b1);
        // The slot-0 bit of a new frame already uses the newly sampled mode
        w_mode_eff    = w_frame_start ? w_mode_in : mode_act_q;
        // Accumulators restart on idle->run and whenever the scheme changes
        w_acc_clear   = w_frame_start && (!busy_q || (w_mode_in != mode_act_q));
    end

    // Next-state for the global counters and frame flags
    always_comb begin
        div_cnt_d  = div_cnt_q;
        slot_d     = slot_q;
        mode_act_d = mode_act_q;
        busy_d     = busy_q;
        strobe_d   = 1'b0;

        if (w_frame_start) begin
            div_cnt_d  = '0;
            slot_d     = '0;
            mode_act_d = w_mode_in;
            busy_d     = 1'b1;
            strobe_d   = 1'b1;
        end else if (w_frame_stop) begin
            div_cnt_d  = '0;
            slot_d     = '0;
            busy_d     = 1'b0;
        end else if (busy_q) begin
            if (w_slot_end) begin
                div_cnt_d = '0;
                slot_d    = w_slot_new;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    // Global control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q  <= '0;
            slot_q     <= '0;
            mode_act_q <= PDM_MODE_SD;
            busy_q     <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            slot_q     <= slot_d;
            mode_act_q <= mode_act_d;
            busy_q     <= busy_d;
            strobe_q   <= strobe_d;
        end
    end

    assign busy         = busy_q;
    assign frame_strobe = strobe_q;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic w_wr_sel;
            // Indices at or above CHANNELS never match, so those writes drop
            assign w_wr_sel = wr_en && (wr_ch == CHW'(i));

            pdm_channel #(
                .MOD_WIDTH (MOD_WIDTH)
            ) u_channel (
                .clk       (clk),
                .rst       (rst),
                .wr_en     (w_wr_sel),
                .wr_data   (wr_data),
                .commit    (w_frame_start),
                .slot_tick (w_slot_tick),
                .slot_new  (w_slot_new),
                .mode_act  (w_mode_eff),
                .acc_clear (w_acc_clear),
                .out_clear (w_frame_stop),
                .pdm_out   (pdm_out[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pdm_modulator_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdm_modulator_mc
// Description : Self-checking bench for pdm_modulator_mc (W=4, 2 channels,
//               2 clocks per slot) against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdm_modulator_mc;

    localparam int CH    = 2;
    localparam int W     = 4;
    localparam int DIV   = 2;
    localparam int NSLOT = 1 << W;
    localparam int FCYC  = NSLOT * DIV;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic          mode;
    logic          wr_en;
    logic [0:0]    wr_ch;
    logic [W-1:0]  wr_data;
    logic [CH-1:0] pdm_out;
    logic          frame_strobe;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // Reference model state: whole-frame view
    bit m_busy;
    int m_pos;
    bit m_mode;
    bit m_fs;
    int m_sp [CH];
    int m_sh [CH];
    int m_a0 [CH];

    pdm_modulator_mc #(
        .CHANNELS       (CH),
        .MOD_WIDTH      (W),
        .PDM_PERIOD_DIV (DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .mode         (mode),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_data      (wr_data),
        .pdm_out      (pdm_out),
        .frame_strobe (frame_strobe),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy = 0; m_pos = 0; m_mode = 0; m_fs = 0;
        for (int c = 0; c < CH; c++) begin
            m_sp[c] = 0; m_sh[c] = 0; m_a0[c] = 0;
        end
    endtask

    // Advance the model by one clock using the inputs seen at that edge
    task automatic model_step();
        bit start;
        if (rst) begin
            model_reset();
            return;
        end
        start = ena && (!m_busy || m_pos == FCYC - 1);
        if (start) begin
            for (int c = 0; c < CH; c++) begin
                if (m_busy && !m_mode) m_a0[c] = (m_a0[c] + NSLOT * m_sp[c]) % NSLOT;
                if (!m_busy || (mode != m_mode)) m_a0[c] = 0;
                m_sp[c] = m_sh[c];
            end
            m_mode = mode; m_busy = 1; m_pos = 0; m_fs = 1;
        end else begin
            m_fs = 0;
            if (m_busy) begin
                if (m_pos == FCYC - 1) begin
                    m_busy = 0; m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
        end
        if (wr_en && int'(wr_ch) < CH) m_sh[wr_ch] = int'(wr_data);
    endtask

    // Expected output bit: exactly sp highs per frame, spread (SD) or packed (PWM)
    function automatic logic exp_bit(int c);
        int s;
        if (!m_busy) return 1'b0;
        s = m_pos / DIV;
        if (m_mode) return (s < m_sp[c]);
        return (((m_a0[c] + (s + 1) * m_sp[c]) / NSLOT) - ((m_a0[c] + s * m_sp[c]) / NSLOT)) != 0;
    endfunction

    task automatic check_outputs();
        logic [CH-1:0] e;
        for (int c = 0; c < CH; c++) e[c] = exp_bit(c);
        checks++;
        assert (pdm_out === e) else begin
            errors++;
            $error("FAIL pdm_out pos=%0d observed=%b expected=%b", m_pos, pdm_out, e);
        end
        checks++;
        assert (busy === m_busy) else begin
            errors++;
            $error("FAIL busy pos=%0d observed=%b expected=%b", m_pos, busy, m_busy);
        end
        checks++;
        assert (frame_strobe === m_fs) else begin
            errors++;
            $error("FAIL frame_strobe pos=%0d observed=%b expected=%b", m_pos, frame_strobe, m_fs);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic write(input int c, input int d);
        wr_en = 1'b1; wr_ch = c[0:0]; wr_data = d[W-1:0];
        cycle();
        wr_en = 1'b0;
    endtask

    // Run until the next edge will be a frame boundary (bounded)
    task automatic run_to_frame_end();
        for (int i = 0; i < FCYC + 2; i++) begin
            if (m_busy && m_pos == FCYC - 1) return;
            cycle();
        end
        checks++; errors++;
        $error("FAIL frame_end_timeout observed=pos%0d expected=pos%0d", m_pos, FCYC - 1);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; mode = 1'b0;
        wr_en = 1'b0; wr_ch = '0; wr_data = '0;
        model_reset();

        // Reset state
        repeat (2) cycle();
        rst = 1'b0;
        repeat (3) cycle();

        // Sigma-delta, ch0 sp=4
        write(0, 4);
        ena = 1'b1; mode = 1'b0;
        repeat (2 * FCYC) cycle();

        // PWM, ch1 sp=4 written mid-frame
        mode = 1'b1;
        repeat (7) cycle();
        write(1, 4);
        repeat (3 * FCYC) cycle();

        // Mid-frame write of full scale, then a write colliding with the commit
        repeat (5) cycle();
        write(0, 15);
        run_to_frame_end();
        write(1, 0);
        repeat (2 * FCYC) cycle();
        write(1, 15);
        repeat (2 * FCYC) cycle();

        // Back to sigma-delta with ch0=4
        write(0, 4);
        mode = 1'b0;
        repeat (2 * FCYC) cycle();

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            wr_en   = ($urandom % 4) == 0;
            wr_ch   = 1'($urandom % 2);
            wr_data = W'($urandom);
            if (($urandom % 64) == 0) mode = ~mode;
            ena     = ($urandom % 50) != 0;
            cycle();
        end
        wr_en = 1'b0; ena = 1'b1;

        // ena dropped in slot 5: frame completes then idles
        write(0, 4);
        run_to_frame_end();
        repeat (1 + 5 * DIV) cycle();
        ena = 1'b0;
        repeat (FCYC + 8) cycle();

        // Asynchronous reset mid-slot while busy
        write(0, 9);
        write(1, 7);
        ena = 1'b1;
        repeat (FCYC + 11) cycle();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        assert (pdm_out === '0 && busy === 1'b0 && frame_strobe === 1'b0) else begin
            errors++;
            $error("FAIL async_reset observed=%b/%b/%b expected=0/0/0", pdm_out, busy, frame_strobe);
        end
        cycle();
        rst = 1'b0;
        repeat (FCYC + 4) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
